// File: rtl/instr_feeder.sv
// instr_feeder: streams a host-loaded program into the core under valid/ready; FEEDER_LOOP_EN makes it replay forever
module instr_feeder #(
   parameter int DEPTH  = 16,
   parameter int WIDTH  = 7,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W:0]   len,
   output logic [WIDTH-1:0]  instr_out,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              busy,
   output logic              done,
   output logic [7:0]        sent
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic              valid_q, valid_d;
   logic [7:0]        sent_q, sent_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              go, xfer, last;
   always_comb begin
      go      = start && len != '0 && len <= MAX_LEN;
      xfer    = state_q == RUN && valid_q && instr_ready;
      last    = {1'b0, ptr_q} == len_q - LEN_ONE;
      state_d = state_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      out_d   = out_q;
      valid_d = valid_q;
      sent_d  = xfer ? sent_q + 8'd1 : sent_q;
      if (stop) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else if (state_q != RUN) begin
         if (go) begin
            state_d = RUN;
            len_d   = len;
            ptr_d   = '0;
            out_d   = mem_q[0];
            valid_d = 1'b1;
            sent_d  = 8'd0;
         end
      end else if (xfer) begin
         if (!last) begin
            ptr_d = ptr_q + ADDR_W'(1);
            out_d = mem_q[ptr_q + ADDR_W'(1)];
         end else begin
`ifdef FEEDER_LOOP_EN
            ptr_d = '0;
            out_d = mem_q[0];
`else
            state_d = DONE;
            valid_d = 1'b0;
`endif
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         len_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         sent_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         len_q   <= len_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         sent_q  <= sent_d;
      end
   end
   // program memory survives reset; loads are locked out while streaming
   always_ff @(posedge clk) begin
      if (wr_en && state_q != RUN) mem_q[wr_addr] <= wr_data;
   end
   assign instr_out   = out_q;
   assign instr_valid = valid_q;
   assign busy        = state_q == RUN;
   assign done        = state_q == DONE;
   assign sent        = sent_q;
endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: directed stimulus, queue-level program model checked every cycle, plus literal checkpoints
module tb_instr_feeder;
   localparam int DEPTH = 16;
   localparam int WIDTH = 7;
   localparam int AW    = 4;
   logic             clk = 0, reset = 1, wr_en = 0, start = 0, stop = 0, instr_ready = 0;
   logic [AW-1:0]    wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic [AW:0]      len = '0;
   logic [WIDTH-1:0] instr_out;
   logic             instr_valid, busy, done;
   logic [7:0]       sent;
   instr_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .len(len), .instr_out(instr_out), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .busy(busy), .done(done), .sent(sent)
   );
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0;
   bit chk_en = 0;
   logic [WIDTH-1:0] cap[$];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // model: snapshot the program on start, then walk it word by word
   logic [WIDTH-1:0] m_mem [DEPTH];
   logic [WIDTH-1:0] m_prog[$];
   logic [WIDTH-1:0] m_out = '0;
   logic [7:0]       m_sent = '0;
   bit m_valid = 0, m_busy = 0, m_done = 0;
   int m_idx = 0;
   always @(posedge clk) begin
      bit xf, wb;
      if (reset) begin
         m_valid = 0; m_out = '0; m_sent = '0; m_busy = 0; m_done = 0; m_idx = 0;
      end else begin
         wb = m_busy;
         xf = m_busy && m_valid && instr_ready;
         if (xf) m_sent = m_sent + 8'd1;
         if (stop) begin
            m_busy = 0; m_done = 0; m_valid = 0;
         end else if (!m_busy) begin
            if (start && len >= 1 && len <= DEPTH) begin
               m_prog = {};
               for (int i = 0; i < int'(len); i++) m_prog.push_back(m_mem[i]);
               m_idx = 0; m_busy = 1; m_done = 0; m_valid = 1; m_out = m_prog[0]; m_sent = '0;
            end
         end else if (xf) begin
            m_idx++;
            if (m_idx == m_prog.size()) begin
`ifdef FEEDER_LOOP_EN
               m_idx = 0; m_out = m_prog[0];
`else
               m_busy = 0; m_done = 1; m_valid = 0;
`endif
            end else m_out = m_prog[m_idx];
         end
         if (wr_en && !wb) m_mem[wr_addr] = wr_data;
      end
   end
   always @(negedge clk) begin
      if (chk_en) begin
         check("instr_out", instr_out, m_out);
         check("instr_valid", instr_valid, m_valid);
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("sent", sent, m_sent);
         if (!reset && instr_valid && instr_ready) cap.push_back(instr_out);
      end
   end
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask
   task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      wr_en = 1; wr_addr = a; wr_data = d; tick(1); wr_en = 0;
   endtask
   task automatic go(input logic [AW:0] l);
      start = 1; len = l; tick(1); start = 0;
   endtask
   task automatic check_cap(input string name, input logic [WIDTH-1:0] exp[$]);
      check($sformatf("%s_count", name), cap.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         check($sformatf("%s_w%0d", name, i), (i < cap.size()) ? cap[i] : 'x, exp[i]);
   endtask
   task automatic end_prog(input int n);
      int k = 0;
      while (cap.size() < n && k < 200) begin tick(1); k++; end
      check("words_seen", cap.size(), n);
`ifdef FEEDER_LOOP_EN
      check("loop_done_low", done, 0);
      stop = 1; instr_ready = 0; tick(1); stop = 0;
      check("stopped_busy", busy, 0);
`else
      check("end_done", done, 1);
      check("end_valid", instr_valid, 0);
      check("end_sent", sent, n);
`endif
   endtask
   initial begin
      @(posedge clk); #2; chk_en = 1;
      tick(1);
      check("rst_out", instr_out, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sent", sent, 0);
      reset = 0;
      wr(0, 7'h01); wr(1, 7'h22); wr(2, 7'h43); wr(3, 7'h7F);
      cap = {}; instr_ready = 1; go(4);
      check("start_latency_out", instr_out, 7'h01);
      check("start_latency_valid", instr_valid, 1);
      end_prog(4);
      check_cap("seq", '{7'h01, 7'h22, 7'h43, 7'h7F});
      begin
         bit pat[4] = '{1, 0, 0, 1};
         cap = {}; instr_ready = 1; go(4);
         for (int c = 0; c < 40 && cap.size() < 4; c++) begin instr_ready = pat[c % 4]; tick(1); end
         end_prog(4);
         check_cap("stall", '{7'h01, 7'h22, 7'h43, 7'h7F});
      end
      stop = 1; tick(1); stop = 0;
      go(0);
      check("len0_busy", busy, 0);
      check("len0_valid", instr_valid, 0);
      go(17);
      check("len17_busy", busy, 0);
      cap = {}; instr_ready = 1; go(4);
      tick(1);
      stop = 1; tick(1); stop = 0;
      check("stop_sent", sent, 2);
      check("stop_busy", busy, 0);
      check("stop_valid", instr_valid, 0);
      check("stop_done", done, 0);
      cap = {}; go(4); end_prog(4);
      check_cap("replay", '{7'h01, 7'h22, 7'h43, 7'h7F});
      cap = {}; instr_ready = 0; go(4);
      wr(1, 7'h55);
      instr_ready = 1; end_prog(4);
      check_cap("run_write", '{7'h01, 7'h22, 7'h43, 7'h7F});
      wr(1, 7'h55);
      cap = {}; instr_ready = 1; go(4); end_prog(4);
      check_cap("rewrite", '{7'h01, 7'h55, 7'h43, 7'h7F});
      go(4); tick(1);
      reset = 1; tick(1);
      check("mid_rst_out", instr_out, 0);
      check("mid_rst_valid", instr_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_sent", sent, 0);
      reset = 0;
      cap = {}; instr_ready = 1; go(2);
`ifdef FEEDER_LOOP_EN
      begin
         int k = 0;
         while (cap.size() < 6 && k < 50) begin tick(1); k++; end
         check("loop_sent", sent, 6);
         check("loop_done", done, 0);
         check("loop_busy", busy, 1);
         check_cap("loop", '{7'h01, 7'h55, 7'h01, 7'h55, 7'h01, 7'h55});
         k = 0;
         while (cap.size() < 258 && k < 400) begin tick(1); k++; end
         check("loop_wrap_sent", sent, 2);
         stop = 1; instr_ready = 0; tick(1); stop = 0;
         check("loop_stop_busy", busy, 0);
      end
`else
      end_prog(2);
      check_cap("len2", '{7'h01, 7'h55});
`endif
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
